// File: rtl/alu_pkg.sv
// Shared ALU constants and the divider FSM encoding.
// Used by divider_4bit and its div_step datapath.
package alu_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int QUOT_W     = 8;
    localparam int REM_W      = 4;
    localparam int DIV_ITERS  = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare-and-subtract of the 5-bit trial value t against {0,d}.
// The final borrow decides whether the difference is kept or t is restored.
module div_step
    import alu_pkg::*;
(
    input  logic [REM_W:0]     t,
    input  logic [DIVISOR_W-1:0] d,
    output logic [REM_W-1:0]   r_next,
    output logic               q_bit
);

    logic [REM_W-1:0] diff;
    logic [REM_W:0]   borrow;
    logic             borrow_msb;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < REM_W; i++) begin : g_sub
        full_sub u_sub (
            .a    (t[i]),
            .b    (d[i]),
            .bin  (borrow[i]),
            .diff (diff[i]),
            .bout (borrow[i+1])
        );
    end

    // The divisor's top bit is always 0, so the fifth stage reduces to its borrow term.
    assign borrow_msb = ~t[REM_W] & borrow[REM_W];

    assign q_bit  = ~borrow_msb;
    assign r_next = q_bit ? diff : t[REM_W-1:0];

endmodule

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/divider_4bit.sv
// Sequential restoring divider (8-bit / 4-bit), one quotient bit per clock with start/busy/done.
// Optional feature: define DIVIDER_ZERO_CHECK_EN to short-circuit a zero divisor in one cycle.
module divider_4bit
    import alu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [QUOT_W-1:0]     o_quot,
    output logic [REM_W-1:0]      o_rem,
    output logic                  o_div_zero
);

    div_state_t             state;
    logic [DIVIDEND_W-1:0]  q;
    logic [REM_W-1:0]       r;
    logic [DIVISOR_W-1:0]   d;
    logic [CNT_W-1:0]       cnt;

    logic [REM_W:0]         t;
    logic [REM_W-1:0]       r_next;
    logic                   q_bit;
    logic [DIVIDEND_W-1:0]  q_next;
    logic                   last_iter;
    logic                   zero_in;
    logic                   zero_run;

    assign t         = {r, q[DIVIDEND_W-1]};
    assign q_next    = {q[DIVIDEND_W-2:0], q_bit};
    assign last_iter = (cnt == CNT_W'(DIV_ITERS - 1));

    div_step u_step (
        .t      (t),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

`ifdef DIVIDER_ZERO_CHECK_EN
    logic accept;
    logic finish;
    logic div_zero_reg;

    assign zero_in    = (i_divisor == '0);
    assign accept     = i_start && (state != ST_RUN);
    assign finish     = (state == ST_RUN) && (zero_run || last_iter);
    assign o_div_zero = div_zero_reg;

    // A zero divisor preloads the architectural result and finishes on the next edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            zero_run     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (accept)
                zero_run <= zero_in;
            if (finish)
                div_zero_reg <= zero_run;
        end
    end
`else
    assign zero_in    = 1'b0;
    assign zero_run   = 1'b0;
    assign o_div_zero = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            q      <= '0;
            r      <= '0;
            d      <= '0;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_quot <= '0;
            o_rem  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                // DONE accepts a new start just like IDLE, giving back-to-back operation.
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        q      <= zero_in ? {DIVIDEND_W{1'b1}} : i_dividend;
                        r      <= zero_in ? i_dividend[REM_W-1:0] : '0;
                        d      <= i_divisor;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (zero_run) begin
                        o_quot <= q;
                        o_rem  <= r;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        q   <= q_next;
                        r   <= r_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            o_quot <= q_next;
                            o_rem  <= r_next;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
